// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues reads to instruction memory, buffers responses in a
// 2-entry FIFO for decode. Optional perf counters are enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_request,
  output logic              imem_we_re,
  output logic [3:0]        imem_mask,
  output logic [ADDR_W-1:0] imem_address,
  input  logic              imem_valid,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
`endif
);

  logic [31:0] pc_q;
  logic [31:0] inflight_pc;
  logic        inflight;
  logic        active;
  logic [1:0]  count;
  logic [31:0] head_instr, head_pc;
  logic [31:0] tail_instr, tail_pc;

  logic        pop, push, issue;
  logic [1:0]  occupancy;

  assign pop  = if_valid && if_ready && !redirect_valid;
  assign push = imem_valid && inflight && !redirect_valid;

  // Occupancy after this cycle's push/pop; issuing only below 2 reserves a slot for the response.
  assign occupancy = count + {1'b0, push} - {1'b0, pop};
  assign issue     = active && !redirect_valid && (occupancy < 2'd2);

  assign imem_request = issue;
  assign imem_we_re   = 1'b0;
  assign imem_mask    = 4'b1111;
  assign imem_address = pc_q[ADDR_W+1:2];

  assign if_valid = (count != 2'd0) && !redirect_valid;
  assign if_instr = head_instr;
  assign if_pc    = head_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      active      <= 1'b0;
      count       <= '0;
      head_instr  <= '0;
      head_pc     <= '0;
      tail_instr  <= '0;
      tail_pc     <= '0;
    end else begin
      active <= 1'b1;
      if (redirect_valid) begin
        count    <= '0;
        inflight <= 1'b0;
        pc_q     <= redirect_pc & ~32'd3;
      end else begin
        inflight <= issue;
        if (issue) begin
          inflight_pc <= pc_q;
          pc_q        <= pc_q + 32'd4;
        end
        count <= occupancy;
        // A push lands at the head when the FIFO is (or is becoming) empty, otherwise at the tail.
        if (push && (count == 2'd0 || (pop && count == 2'd1))) begin
          head_instr <= imem_data;
          head_pc    <= inflight_pc;
        end else if (pop) begin
          head_instr <= tail_instr;
          head_pc    <= tail_pc;
        end
        if (push && !pop && count == 2'd1) begin
          tail_instr <= imem_data;
          tail_pc    <= inflight_pc;
        end
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (pop)
        fetch_count <= fetch_count + 32'd1;
      if (if_valid && !if_ready)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
